// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer and fetch controller for a one-cycle-latency instruction memory
module fetch_sequencer #(
  parameter int                   PC_W     = 10,
  parameter int                   INSTR_W  = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter logic [PC_W-1:0]      END_PC   = '1,
  parameter logic [INSTR_W-1:0]   NOP      = '0
) (
  input  logic               CLK_SYS,
  input  logic               RST_SYS,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    mem_pc,
  input  logic [INSTR_W-1:0] mem_instruction,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic               busy,
  output logic               done,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic [PC_W-1:0] rd_pc, rd_pc_n;
  logic            rd_valid, rd_valid_n;
  logic            accept;

  // The word on the read port belongs to rd_pc; a same-cycle redirect marks it wrong-path.
  assign if_pc          = rd_pc;
  assign if_valid       = rd_valid & ~redirect;
  assign if_instruction = if_valid ? mem_instruction : NOP;
  assign accept         = if_valid & ~stall;
  assign busy           = (state == RUN);
  assign done           = (state == DONE);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    rd_pc_n    = rd_pc;
    rd_valid_n = rd_valid;
    mem_pc     = rd_pc;
    case (state)
      IDLE: begin
        rd_valid_n = 1'b0;
        if (start) begin
          mem_pc     = fetch_pc;
          rd_pc_n    = fetch_pc;
          rd_valid_n = 1'b1;
          fetch_pc_n = fetch_pc + PC_W'(1);
          state_n    = (fetch_pc == END_PC) ? DONE : RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          mem_pc     = redirect_pc;
          rd_pc_n    = redirect_pc;
          rd_valid_n = 1'b1;
          fetch_pc_n = redirect_pc + PC_W'(1);
          if (redirect_pc == END_PC) state_n = DONE;
        end else if (!stall) begin
          mem_pc     = fetch_pc;
          rd_pc_n    = fetch_pc;
          rd_valid_n = 1'b1;
          fetch_pc_n = fetch_pc + PC_W'(1);
          if (fetch_pc == END_PC) state_n = DONE;
        end
      end
      DONE: begin
        // start restarts from RESET_PC regardless of any pending redirect
        if (start) begin
          mem_pc     = RESET_PC;
          rd_pc_n    = RESET_PC;
          rd_valid_n = 1'b1;
          fetch_pc_n = RESET_PC + PC_W'(1);
          state_n    = (RESET_PC == END_PC) ? DONE : RUN;
        end else if (redirect) begin
          mem_pc     = redirect_pc;
          rd_pc_n    = redirect_pc;
          rd_valid_n = 1'b1;
          fetch_pc_n = redirect_pc + PC_W'(1);
          state_n    = (redirect_pc == END_PC) ? DONE : RUN;
        end else if (!stall) begin
          rd_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (RST_SYS) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_pc    <= RESET_PC;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      rd_pc    <= rd_pc_n;
      rd_valid <= rd_valid_n;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (RST_SYS) begin
      instr_count <= 16'd0;
    end else if (start && (state != RUN)) begin
      instr_count <= 16'd0;
    end else if (accept && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, stall_a, redirect_a;
  logic [9:0]  redirect_pc_a, mem_pc_a, if_pc_a;
  logic [31:0] mem_q_a, if_instr_a;
  logic        if_valid_a, busy_a, done_a;
  logic [15:0] count_a;

  logic        start_b, stall_b, redirect_b;
  logic [9:0]  redirect_pc_b, mem_pc_b, if_pc_b;
  logic [31:0] mem_q_b, if_instr_b;
  logic        if_valid_b, busy_b, done_b;
  logic [15:0] count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    return {12'hC0D, a, ~a};
  endfunction

  always @(posedge clk) begin
    mem_q_a <= word(mem_pc_a);
    mem_q_b <= word(mem_pc_b);
  end

  fetch_sequencer #(.PC_W(10), .INSTR_W(32), .RESET_PC(10'd0), .END_PC(10'd26), .NOP(32'h0)) u_a (
    .CLK_SYS(clk), .RST_SYS(rst), .start(start_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_pc(redirect_pc_a), .mem_pc(mem_pc_a), .mem_instruction(mem_q_a),
    .if_instruction(if_instr_a), .if_pc(if_pc_a), .if_valid(if_valid_a),
    .busy(busy_a), .done(done_a), .instr_count(count_a));

  fetch_sequencer #(.PC_W(10), .INSTR_W(32), .RESET_PC(10'd0), .END_PC(10'd1023), .NOP(32'h0)) u_b (
    .CLK_SYS(clk), .RST_SYS(rst), .start(start_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .mem_pc(mem_pc_b), .mem_instruction(mem_q_b),
    .if_instruction(if_instr_b), .if_pc(if_pc_b), .if_valid(if_valid_b),
    .busy(busy_b), .done(done_b), .instr_count(count_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_a = 1'b0; stall_a = 1'b0; redirect_a = 1'b0;
    start_b = 1'b0; redirect_b = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_mem_pc"}, 32'(mem_pc_a), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid_a), 32'd0);
    chk({tag, "_if_instr"}, if_instr_a, 32'h0);
    chk({tag, "_if_pc"}, 32'(if_pc_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_count"}, 32'(count_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = '0;
    start_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;
    repeat (2) @(posedge clk);
    next_cycle();
    #1;
    chk_reset_a("rst");

    // straight run 0..26
    start_a = 1'b1;
    #1;
    chk("run_start_mem_pc", 32'(mem_pc_a), 32'd0);
    for (int k = 1; k <= 27; k++) begin
      next_cycle();
      #1;
      chk($sformatf("run_if_pc_%0d", k), 32'(if_pc_a), 32'(k - 1));
      chk($sformatf("run_valid_%0d", k), 32'(if_valid_a), 32'd1);
      chk($sformatf("run_instr_%0d", k), if_instr_a, word(10'(k - 1)));
      chk($sformatf("run_done_%0d", k), 32'(done_a), (k == 27) ? 32'd1 : 32'd0);
      chk($sformatf("run_count_%0d", k), 32'(count_a), 32'(k - 1));
    end
    next_cycle();
    #1;
    chk("end_valid", 32'(if_valid_a), 32'd0);
    chk("end_instr", if_instr_a, 32'h0);
    chk("end_count", 32'(count_a), 32'd27);
    chk("end_done", 32'(done_a), 32'd1);
    chk("end_busy", 32'(busy_a), 32'd0);

    // restart, then a 3-cycle stall at if_pc=5
    next_cycle();
    start_a = 1'b1;
    #1;
    chk("restart_mem_pc", 32'(mem_pc_a), 32'd0);
    repeat (6) next_cycle();
    #1;
    chk("pre_stall_if_pc", 32'(if_pc_a), 32'd5);
    chk("pre_stall_count", 32'(count_a), 32'd5);
    stall_a = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        next_cycle();
        stall_a = 1'b1;
        #1;
      end
      chk($sformatf("stall_if_pc_%0d", s), 32'(if_pc_a), 32'd5);
      chk($sformatf("stall_instr_%0d", s), if_instr_a, word(10'd5));
      chk($sformatf("stall_mem_pc_%0d", s), 32'(mem_pc_a), 32'd5);
      chk($sformatf("stall_count_%0d", s), 32'(count_a), 32'd5);
    end
    next_cycle();
    #1;
    chk("release_if_pc", 32'(if_pc_a), 32'd5);
    chk("release_instr", if_instr_a, word(10'd5));
    chk("release_mem_pc", 32'(mem_pc_a), 32'd6);
    next_cycle();
    #1;
    chk("post_stall_if_pc", 32'(if_pc_a), 32'd6);
    chk("post_stall_count", 32'(count_a), 32'd6);

    // redirect to 17 while if_pc=9
    repeat (3) next_cycle();
    redirect_a = 1'b1;
    redirect_pc_a = 10'd17;
    #1;
    chk("redir_if_pc", 32'(if_pc_a), 32'd9);
    chk("redir_valid", 32'(if_valid_a), 32'd0);
    chk("redir_instr", if_instr_a, 32'h0);
    chk("redir_mem_pc", 32'(mem_pc_a), 32'd17);
    next_cycle();
    #1;
    chk("redir_tgt_if_pc", 32'(if_pc_a), 32'd17);
    chk("redir_tgt_valid", 32'(if_valid_a), 32'd1);
    chk("redir_tgt_instr", if_instr_a, word(10'd17));
    chk("redir_tgt_count", 32'(count_a), 32'd9);
    next_cycle();
    #1;
    chk("redir_next_if_pc", 32'(if_pc_a), 32'd18);
    chk("redir_next_count", 32'(count_a), 32'd10);

    // redirect and stall together: redirect wins
    redirect_a = 1'b1;
    stall_a = 1'b1;
    redirect_pc_a = 10'd22;
    #1;
    chk("rs_mem_pc", 32'(mem_pc_a), 32'd22);
    chk("rs_valid", 32'(if_valid_a), 32'd0);
    next_cycle();
    #1;
    chk("rs_if_pc", 32'(if_pc_a), 32'd22);
    chk("rs_valid_next", 32'(if_valid_a), 32'd1);
    chk("rs_count", 32'(count_a), 32'd10);
    repeat (4) next_cycle();
    #1;
    chk("rs_end_if_pc", 32'(if_pc_a), 32'd26);
    chk("rs_end_done", 32'(done_a), 32'd1);

    // reset mid-run at if_pc=12
    next_cycle();
    start_a = 1'b1;
    repeat (13) next_cycle();
    #1;
    chk("mid_if_pc", 32'(if_pc_a), 32'd12);
    chk("mid_count", 32'(count_a), 32'd12);
    rst = 1'b1;
    next_cycle();
    #1;
    chk_reset_a("midrst");
    start_a = 1'b1;
    next_cycle();
    #1;
    chk("rerun_if_pc", 32'(if_pc_a), 32'd0);
    chk("rerun_valid", 32'(if_valid_a), 32'd1);
    chk("rerun_busy", 32'(busy_a), 32'd1);
    chk("rerun_count", 32'(count_a), 32'd0);
    next_cycle();
    #1;
    chk("rerun_if_pc1", 32'(if_pc_a), 32'd1);
    chk("rerun_count1", 32'(count_a), 32'd1);

    // END_PC=1023: redirect onto the last address, then out of DONE
    next_cycle();
    start_b = 1'b1;
    next_cycle();
    #1;
    chk("b_if_pc0", 32'(if_pc_b), 32'd0);
    redirect_b = 1'b1;
    redirect_pc_b = 10'd1023;
    #1;
    chk("b_redir_mem_pc", 32'(mem_pc_b), 32'd1023);
    chk("b_redir_valid", 32'(if_valid_b), 32'd0);
    next_cycle();
    #1;
    chk("b_last_if_pc", 32'(if_pc_b), 32'd1023);
    chk("b_last_valid", 32'(if_valid_b), 32'd1);
    chk("b_last_instr", if_instr_b, word(10'd1023));
    chk("b_last_done", 32'(done_b), 32'd1);
    chk("b_last_busy", 32'(busy_b), 32'd0);
    chk("b_last_count", 32'(count_b), 32'd0);
    next_cycle();
    #1;
    chk("b_after_valid", 32'(if_valid_b), 32'd0);
    chk("b_after_count", 32'(count_b), 32'd1);
    chk("b_after_done", 32'(done_b), 32'd1);
    redirect_b = 1'b1;
    redirect_pc_b = 10'd3;
    #1;
    chk("b_out_mem_pc", 32'(mem_pc_b), 32'd3);
    next_cycle();
    #1;
    chk("b_out_if_pc", 32'(if_pc_b), 32'd3);
    chk("b_out_valid", 32'(if_valid_b), 32'd1);
    chk("b_out_busy", 32'(busy_b), 32'd1);
    chk("b_out_count", 32'(count_b), 32'd1);
    next_cycle();
    #1;
    chk("b_seq_if_pc", 32'(if_pc_b), 32'd4);
    chk("b_seq_count", 32'(count_b), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer and fetch controller for the synchronous-read instruction memory (10-bit word address, 32-bit word, one-cycle read latency). It sits between the instruction memory and the decode stage. It generates the fetch address every cycle, tracks which address the returned word belongs to, and handles start, end-of-program, hazard stalls and branch/jump redirects. It also counts delivered instructions for pipeline-hazard test runs.

## Interface
Parameters:
- PC_W, 10, width of the word address and of all PC values
- INSTR_W, 32, instruction width
- RESET_PC, 0, first address fetched after start
- END_PC, 1023, last address fetched; issuing it ends the run
- NOP, 32'h0000_0000, word driven on if_instruction when if_valid=0

Ports:
- CLK_SYS  in  1  system clock, all state on rising edge
- RST_SYS  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse: begin fetching at RESET_PC
- stall  in  1  hazard unit: decode cannot accept; hold current word
- redirect  in  1  branch/jump taken; squash the presented word
- redirect_pc  in  PC_W  target address, valid with redirect
- mem_pc  out  PC_W  address to instruction memory, combinational
- mem_instruction  in  INSTR_W  memory read data for the address presented last cycle
- if_instruction  out  INSTR_W  word to decode
- if_pc  out  PC_W  address of if_instruction
- if_valid  out  1  if_instruction is a live fetched word
- busy  out  1  state is RUN
- done  out  1  state is DONE
- instr_count  out  16  number of words accepted by decode, saturating at 16'hFFFF

## Operation
Internal registers:
- fetch_pc: next address to issue
- rd_pc, rd_valid: address issued last cycle and its liveness
- state: IDLE, RUN, DONE

Output rules:
- if_pc = rd_pc.
- if_valid = rd_valid & ~redirect.
- if_instruction = if_valid ? mem_instruction : NOP.
- A word is accepted when if_valid & ~stall; acceptance increments instr_count.

The same-cycle redirect squashes the presented word, which is on the wrong path.

Issue rules in RUN, by priority:
1. redirect: mem_pc=redirect_pc; rd_pc<=redirect_pc; rd_valid<=1; fetch_pc<=redirect_pc+1. Stall is ignored this cycle.
2. stall: mem_pc=rd_pc, so the same word is re-read. rd_pc, rd_valid and fetch_pc are unchanged.
3. Otherwise: mem_pc=fetch_pc; rd_pc<=fetch_pc; rd_valid<=1; fetch_pc<=fetch_pc+1.

PC arithmetic is modulo 2^PC_W (1023+1 -> 0). Wrap is only reachable when END_PC is skipped by a redirect.

End of program:
- An issue, either by rule 1 or rule 3, whose address equals END_PC moves RUN -> DONE at the next edge.

State transitions:
- IDLE: mem_pc=rd_pc; rd_valid=0. start performs a rule-3 issue of fetch_pc (=RESET_PC) and moves to RUN. redirect and stall are ignored.
- RUN: rules above.
- DONE: nothing new is issued; mem_pc=rd_pc.
  - The END_PC word stays presented while stall=1.
  - When stall=0 and not redirect, rd_valid<=0.
  - start: fetch_pc<=RESET_PC, then a rule-3 issue of RESET_PC; go to RUN. start wins over redirect.
  - redirect: rule 1; go to RUN, or stay in DONE if redirect_pc==END_PC.

instr_count clears on reset and on start only.

## Timing
- Reset values: state=IDLE, fetch_pc=rd_pc=RESET_PC, rd_valid=0, instr_count=0. Outputs: mem_pc=RESET_PC, if_valid=0, if_instruction=NOP, if_pc=RESET_PC, busy=0, done=0.
- Reset mid-run aborts immediately; the next cycle shows reset values.
- Fetch latency: an address is issued on mem_pc in cycle t; its word is on if_instruction with if_valid=1 in cycle t+1.
- Throughput: one word per cycle with no stall.
- Redirect penalty: one squashed word (the cycle redirect is high). The target word appears at t+1.
- Stall holds if_instruction and if_pc bit-stable for every stalled cycle. Release delivers the next sequential word one cycle after stall falls.
- done asserts the cycle after END_PC is issued, coincident with the END_PC word on if_instruction.

## Test plan
- Straight run, RESET_PC=0, END_PC=26: start at cycle 0 -> if_pc 0..26 on cycles 1..27, if_valid=1 throughout; done=1 from cycle 27; instr_count=27; if_valid=0 from cycle 28.
- Stall: 3-cycle stall while if_pc=5 -> if_pc=5 with identical data for 4 cycles; next word if_pc=6; no word lost or duplicated in instr_count.
- Redirect: redirect_pc=17 while if_pc=9 -> if_valid=0 that cycle; next if_pc=17, then 18; instr_count skips 9.
- Redirect with stall in the same cycle -> redirect wins; if_pc=target next cycle.
- Redirect to 1023 with END_PC=1023 -> stays in DONE; word 1023 delivered once. Redirect from DONE to 3 -> RUN, fetching from 3.
- RST_SYS asserted mid-run at if_pc=12 -> next cycle all outputs at reset values; start restarts from 0 with instr_count=0.
